// File: rtl/multi_host_bus.sv
// multi_host_bus: shared single-channel interconnect between NrHosts requesters
// and NrDevices memory-mapped devices. Round-robin arbitration, address decode
// with lowest-index priority, variable-latency device responses, decode-error
// and timeout-error responses, and a saturating error counter.
//
// Handshake: a host raises host_req_i with stable fields and holds them until
// host_gnt_o is seen high in the same cycle; the grant is the acceptance. Each
// accepted request produces exactly one host_rvalid_o pulse to that host (data,
// device error, decode error or timeout). Device side: device_req_o is a single
// cycle pulse and the device answers later with one device_rvalid_i pulse.
module multi_host_bus #(
  parameter int NrHosts       = 2,
  parameter int NrDevices     = 3,
  parameter int DataWidth     = 32,
  parameter int AddressWidth  = 32,
  parameter int TimeoutCycles = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_i,

  input  logic                      host_req_i    [NrHosts],
  input  logic [AddressWidth-1:0]   host_addr_i   [NrHosts],
  input  logic                      host_we_i     [NrHosts],
  input  logic [DataWidth/8-1:0]    host_be_i     [NrHosts],
  input  logic [DataWidth-1:0]      host_wdata_i  [NrHosts],
  output logic                      host_gnt_o    [NrHosts],
  output logic                      host_rvalid_o [NrHosts],
  output logic [DataWidth-1:0]      host_rdata_o  [NrHosts],
  output logic                      host_err_o    [NrHosts],

  output logic                      device_req_o    [NrDevices],
  output logic [AddressWidth-1:0]   device_addr_o   [NrDevices],
  output logic                      device_we_o     [NrDevices],
  output logic [DataWidth/8-1:0]    device_be_o     [NrDevices],
  output logic [DataWidth-1:0]      device_wdata_o  [NrDevices],
  input  logic                      device_rvalid_i [NrDevices],
  input  logic [DataWidth-1:0]      device_rdata_i  [NrDevices],
  input  logic                      device_err_i    [NrDevices],

  input  logic [AddressWidth-1:0]   cfg_device_addr_base [NrDevices],
  input  logic [AddressWidth-1:0]   cfg_device_addr_mask [NrDevices],

  output logic [15:0]               err_count_o,
  output logic [1:0]                dbg_state_o
);

  localparam int HIW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int DIW = (NrDevices > 1) ? $clog2(NrDevices) : 1;
  localparam int CW  = $clog2(TimeoutCycles);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RESP = 2'd1,
    ERR_RESP  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [HIW-1:0]  last_host_q, last_host_d;
  logic [HIW-1:0]  owner_q, owner_d;
  logic [DIW-1:0]  dev_q, dev_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [15:0]     err_count_q, err_count_d;

  logic                    any_req;
  logic [HIW-1:0]          win_idx;
  logic [HIW-1:0]          cand;
  logic [AddressWidth-1:0] sel_addr;
  logic                    dec_hit;
  logic [DIW-1:0]          dec_idx;
  logic                    err_inc;

  // Round-robin search starting one past the last winner.
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= NrHosts; i++) begin
      cand = HIW'((int'(last_host_q) + i) % NrHosts);
      if (!any_req && host_req_i[cand]) begin
        any_req = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Address decode of the arbitration winner; scanning downwards lets the lowest hit win.
  always_comb begin
    sel_addr = host_addr_i[win_idx];
    dec_hit  = 1'b0;
    dec_idx  = '0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((sel_addr & cfg_device_addr_mask[d]) == cfg_device_addr_base[d]) begin
        dec_hit = 1'b1;
        dec_idx = DIW'(d);
      end
    end
  end

  // Next-state and output logic; only the owning host ever sees a response.
  always_comb begin
    state_d     = state_q;
    last_host_d = last_host_q;
    owner_d     = owner_q;
    dev_d       = dev_q;
    cnt_d       = cnt_q;
    err_count_d = err_count_q;
    err_inc     = 1'b0;

    for (int h = 0; h < NrHosts; h++) begin
      host_gnt_o[h]    = 1'b0;
      host_rvalid_o[h] = 1'b0;
      host_err_o[h]    = 1'b0;
      host_rdata_o[h]  = '0;
    end
    // Request fields go to every device; only device_req_o qualifies them.
    for (int d = 0; d < NrDevices; d++) begin
      device_req_o[d]   = 1'b0;
      device_addr_o[d]  = sel_addr;
      device_we_o[d]    = host_we_i[win_idx];
      device_be_o[d]    = host_be_i[win_idx];
      device_wdata_o[d] = host_wdata_i[win_idx];
    end

    case (state_q)
      IDLE: begin
        if (any_req) begin
          host_gnt_o[win_idx] = 1'b1;
          last_host_d         = win_idx;
          owner_d             = win_idx;
          dev_d               = dec_idx;
          cnt_d               = '0;
          if (dec_hit) begin
            device_req_o[dec_idx] = 1'b1;
            state_d               = WAIT_RESP;
          end else begin
            state_d = ERR_RESP;
          end
        end
      end

      WAIT_RESP: begin
        if (device_rvalid_i[dev_q]) begin
          host_rvalid_o[owner_q] = 1'b1;
          host_rdata_o[owner_q]  = device_rdata_i[dev_q];
          host_err_o[owner_q]    = device_err_i[dev_q];
          state_d                = IDLE;
        end else if (cnt_q == CW'(TimeoutCycles - 1)) begin
          // Device gave up on: answer with an error so the host never stalls.
          host_rvalid_o[owner_q] = 1'b1;
          host_err_o[owner_q]    = 1'b1;
          err_inc                = 1'b1;
          state_d                = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ERR_RESP: begin
        host_rvalid_o[owner_q] = 1'b1;
        host_err_o[owner_q]    = 1'b1;
        err_inc                = 1'b1;
        state_d                = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (err_inc && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end
  end

  // State registers; reset makes host 0 the first arbitration winner.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      last_host_q <= HIW'(NrHosts - 1);
      owner_q     <= '0;
      dev_q       <= '0;
      cnt_q       <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      last_host_q <= last_host_d;
      owner_q     <= owner_d;
      dev_q       <= dev_d;
      cnt_q       <= cnt_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_count_o = err_count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_multi_host_bus.sv
// Bench for multi_host_bus: 3 hosts, 3 devices, 8-cycle timeout.
// Directed vector table, hand-written corner sequences, then random
// transactions checked against a transaction-level reference model.
module tb_multi_host_bus;
  localparam int NH = 3;
  localparam int ND = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int BW = DW / 8;
  localparam int T  = 8;

  logic clk = 1'b0;
  logic rst;

  logic          host_req_i    [NH];
  logic [AW-1:0] host_addr_i   [NH];
  logic          host_we_i     [NH];
  logic [BW-1:0] host_be_i     [NH];
  logic [DW-1:0] host_wdata_i  [NH];
  logic          host_gnt_o    [NH];
  logic          host_rvalid_o [NH];
  logic [DW-1:0] host_rdata_o  [NH];
  logic          host_err_o    [NH];

  logic          device_req_o    [ND];
  logic [AW-1:0] device_addr_o   [ND];
  logic          device_we_o     [ND];
  logic [BW-1:0] device_be_o     [ND];
  logic [DW-1:0] device_wdata_o  [ND];
  logic          device_rvalid_i [ND];
  logic [DW-1:0] device_rdata_i  [ND];
  logic          device_err_i    [ND];

  logic [AW-1:0] cfg_base [ND];
  logic [AW-1:0] cfg_mask [ND];
  logic [15:0]   err_count_o;
  logic [1:0]    dbg_state_o;

  multi_host_bus #(
    .NrHosts(NH), .NrDevices(ND), .DataWidth(DW), .AddressWidth(AW), .TimeoutCycles(T)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .host_req_i(host_req_i), .host_addr_i(host_addr_i), .host_we_i(host_we_i),
    .host_be_i(host_be_i), .host_wdata_i(host_wdata_i), .host_gnt_o(host_gnt_o),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
    .device_req_o(device_req_o), .device_addr_o(device_addr_o), .device_we_o(device_we_o),
    .device_be_o(device_be_o), .device_wdata_o(device_wdata_o),
    .device_rvalid_i(device_rvalid_i), .device_rdata_i(device_rdata_i),
    .device_err_i(device_err_i),
    .cfg_device_addr_base(cfg_base), .cfg_device_addr_mask(cfg_mask),
    .err_count_o(err_count_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [NH-1:0] hreq;
  logic [AW-1:0] haddr  [NH];
  logic          hwe    [NH];
  logic [BW-1:0] hbe    [NH];
  logic [DW-1:0] hwdata [NH];

  typedef struct {
    logic [2:0]       req;
    logic [2:0][31:0] addr;
    int               lat;     // 0 = device never answers
    logic             derr;
    logic [31:0]      ddata;
    int               e_host;
    int               e_dev;   // -1 = unmapped
    int               e_cyc;
    logic             e_err;
    logic [31:0]      e_rdata;
    logic [15:0]      e_cnt;   // error count while the transaction runs
  } vec_t;
  vec_t tbl[$];

  int          m_last;
  logic [15:0] m_cnt;

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_hosts();
    for (int h = 0; h < NH; h++) begin
      host_req_i[h]   = hreq[h];
      host_addr_i[h]  = haddr[h];
      host_we_i[h]    = hwe[h];
      host_be_i[h]    = hbe[h];
      host_wdata_i[h] = hwdata[h];
    end
  endtask

  task automatic clear_dev();
    for (int d = 0; d < ND; d++) begin
      device_rvalid_i[d] = 1'b0;
      device_rdata_i[d]  = '0;
      device_err_i[d]    = 1'b0;
    end
  endtask

  task automatic check_outs(input int c, input logic [2:0] eg, input logic [2:0] edq,
                            input logic [2:0] erv, input logic [2:0] eer,
                            input logic [31:0] erd, input logic [15:0] ecnt);
    logic [2:0] g, q, v, e;
    for (int h = 0; h < NH; h++) begin
      g[h] = host_gnt_o[h];
      v[h] = host_rvalid_o[h];
      e[h] = host_err_o[h];
    end
    for (int d = 0; d < ND; d++) q[d] = device_req_o[d];
    check($sformatf("gnt c%0d", c), 64'(g), 64'(eg));
    check($sformatf("dev_req c%0d", c), 64'(q), 64'(edq));
    check($sformatf("rvalid c%0d", c), 64'(v), 64'(erv));
    check($sformatf("err c%0d", c), 64'(e), 64'(eer));
    for (int h = 0; h < NH; h++)
      check($sformatf("rdata h%0d c%0d", h, c), 64'(host_rdata_o[h]), 64'(erv[h] ? erd : 32'h0));
    check($sformatf("err_count c%0d", c), 64'(err_count_o), 64'(ecnt));
  endtask

  // One arbitration + response. Entered and left just after a rising edge.
  task automatic run_txn(input int e_host, input int e_dev, input int lat, input logic derr,
                         input logic [31:0] ddata, input int e_cyc, input logic e_err,
                         input logic [31:0] e_rdata, input logic [15:0] e_cnt);
    logic [2:0] eg, edq, erv, eer;
    for (int h = 0; h < NH; h++) begin
      hwe[h]    = 1'($urandom_range(0, 1));
      hbe[h]    = 4'($urandom_range(0, 15));
      hwdata[h] = $urandom;
    end
    for (int c = 0; c <= e_cyc; c++) begin
      apply_hosts();
      for (int d = 0; d < ND; d++) begin
        if (d == e_dev && c > 0) begin
          device_rvalid_i[d] = (c == lat);
          device_rdata_i[d]  = ddata;
          device_err_i[d]    = derr;
        end else begin
          // Stray responses from devices not being waited on must be dropped.
          device_rvalid_i[d] = 1'($urandom_range(0, 1));
          device_rdata_i[d]  = $urandom;
          device_err_i[d]    = 1'($urandom_range(0, 1));
        end
      end
      @(negedge clk);
      eg  = (c == 0) ? (3'b001 << e_host) : 3'b000;
      edq = (c == 0 && e_dev >= 0) ? (3'b001 << e_dev) : 3'b000;
      erv = (c == e_cyc) ? (3'b001 << e_host) : 3'b000;
      eer = (c == e_cyc && e_err) ? (3'b001 << e_host) : 3'b000;
      check_outs(c, eg, edq, erv, eer, e_rdata, e_cnt);
      if (c == 0 && e_dev >= 0) begin
        check("dev_addr",  64'(device_addr_o[e_dev]),  64'(haddr[e_host]));
        check("dev_we",    64'(device_we_o[e_dev]),    64'(hwe[e_host]));
        check("dev_be",    64'(device_be_o[e_dev]),    64'(hbe[e_host]));
        check("dev_wdata", 64'(device_wdata_o[e_dev]), 64'(hwdata[e_host]));
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    hreq = '0;
    apply_hosts();
    clear_dev();
    @(posedge clk); #1;
    @(negedge clk);
    check_outs(-1, 3'b0, 3'b0, 3'b0, 3'b0, 32'h0, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_outs(-2, 3'b0, 3'b0, 3'b0, 3'b0, 32'h0, 16'h0);
    @(posedge clk); #1;
  endtask

  task automatic add_vec(input logic [2:0] req, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] a2, input int lat, input logic derr,
                         input logic [31:0] ddata, input int e_host, input int e_dev,
                         input int e_cyc, input logic e_err, input logic [31:0] e_rdata,
                         input logic [15:0] e_cnt);
    vec_t v;
    v.req = req; v.addr[0] = a0; v.addr[1] = a1; v.addr[2] = a2;
    v.lat = lat; v.derr = derr; v.ddata = ddata;
    v.e_host = e_host; v.e_dev = e_dev; v.e_cyc = e_cyc;
    v.e_err = e_err; v.e_rdata = e_rdata; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  function automatic int model_decode(input logic [31:0] a);
    for (int d = 0; d < ND; d++)
      if ((a & cfg_mask[d]) == cfg_base[d]) return d;
    return -1;
  endfunction

  // ---------------- test ----------------
  initial begin
    int w, dv, lat, cyc;
    logic derr, eerr;
    logic [31:0] ddata, erd;

    cfg_base[0] = 32'h0010_0000; cfg_mask[0] = 32'hFFF0_0000;  // RAM
    cfg_base[1] = 32'h0002_0000; cfg_mask[1] = 32'hFFFF_0000;  // sim control
    cfg_base[2] = 32'h0002_0000; cfg_mask[2] = 32'hFFFE_0000;  // timer, overlaps sim control
    for (int h = 0; h < NH; h++) begin
      haddr[h] = '0; hwe[h] = 1'b0; hbe[h] = '0; hwdata[h] = '0;
    end

    // req, addr0..2, lat, derr, ddata, host, dev, cycle, err, rdata, count
    add_vec(3'b001, 32'h0010_0010, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 1, 0, 32'hDEAD_BEEF, 0);
    add_vec(3'b001, 32'h0005_0000, 0, 0, 1, 0, 32'h1111_1111, 0, -1, 1, 1, 0, 0);
    add_vec(3'b010, 0, 32'h0002_0004, 0, 3, 1, 32'h0000_1234, 1, 1, 3, 1, 32'h0000_1234, 1);
    add_vec(3'b100, 0, 0, 32'h0003_0008, 2, 0, 32'hA5A5_0000, 2, 2, 2, 0, 32'hA5A5_0000, 1);
    for (int i = 0; i < 6; i++)
      add_vec(3'b111, 32'h0010_0000, 32'h0010_0004, 32'h0010_0008, 1, 0, 32'hC0DE_0000 + i,
              i % 3, 0, 1, 0, 32'hC0DE_0000 + i, 1);
    add_vec(3'b101, 32'h0010_0000, 0, 32'h0010_0100, 1, 0, 32'h10, 0, 0, 1, 0, 32'h10, 1);
    add_vec(3'b101, 32'h0010_0000, 0, 32'h0010_0100, 1, 0, 32'h20, 2, 0, 1, 0, 32'h20, 1);
    add_vec(3'b110, 0, 32'h0002_0000, 32'h0003_0000, 1, 0, 32'h30, 1, 1, 1, 0, 32'h30, 1);
    add_vec(3'b100, 0, 0, 32'h0003_0000, 0, 0, 32'h99, 2, 2, T, 1, 0, 1);
    add_vec(3'b001, 32'h001F_FFFC, 0, 0, T, 0, 32'h77, 0, 0, T, 0, 32'h77, 2);
    add_vec(3'b010, 0, 32'h0004_0000, 0, 1, 0, 32'h55, 1, -1, 1, 1, 0, 2);
    add_vec(3'b100, 0, 0, 32'h0003_FFFC, 7, 1, 32'h66, 2, 2, 7, 1, 32'h66, 3);

    do_reset();

    // Directed table, issued back to back with requests held.
    for (int i = 0; i < tbl.size(); i++) begin
      hreq = tbl[i].req;
      for (int h = 0; h < NH; h++) haddr[h] = tbl[i].addr[h];
      run_txn(tbl[i].e_host, tbl[i].e_dev, tbl[i].lat, tbl[i].derr, tbl[i].ddata,
              tbl[i].e_cyc, tbl[i].e_err, tbl[i].e_rdata, tbl[i].e_cnt);
    end

    // Timeout followed by a late device answer in cycle 10 that must go nowhere.
    hreq = 3'b001; haddr[0] = 32'h0003_0000;
    run_txn(0, 2, 0, 0, 32'h0, T, 1, 32'h0, 16'd3);
    hreq = '0; apply_hosts(); clear_dev();
    @(negedge clk);
    check_outs(9, 3'b0, 3'b0, 3'b0, 3'b0, 32'h0, 16'd4);
    @(posedge clk); #1;
    device_rvalid_i[2] = 1'b1; device_rdata_i[2] = 32'hBAD0_0BAD;
    @(negedge clk);
    check_outs(10, 3'b0, 3'b0, 3'b0, 3'b0, 32'h0, 16'd4);
    @(posedge clk); #1;
    clear_dev();

    // Reset while waiting on a device: no response, late rvalid dropped, host 0 next.
    hreq = 3'b010; haddr[1] = 32'h0010_0000; apply_hosts();
    @(negedge clk);
    check_outs(100, 3'b010, 3'b001, 3'b0, 3'b0, 32'h0, 16'd4);
    @(posedge clk); #1;
    hreq = '0; apply_hosts();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_outs(101 + c, 3'b0, 3'b0, 3'b0, 3'b0, 32'h0, 16'd4);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(negedge clk);
    check_outs(103, 3'b0, 3'b0, 3'b0, 3'b0, 32'h0, 16'd4);
    @(posedge clk); #1;
    rst = 1'b0;
    device_rvalid_i[0] = 1'b1; device_rdata_i[0] = 32'h00BA_DBAD;
    @(negedge clk);
    check_outs(104, 3'b0, 3'b0, 3'b0, 3'b0, 32'h0, 16'd0);
    @(posedge clk); #1;
    clear_dev();
    hreq = 3'b111;
    haddr[0] = 32'h0010_0000; haddr[1] = 32'h0010_0004; haddr[2] = 32'h0010_0008;
    run_txn(0, 0, 1, 0, 32'hFEED_0001, 1, 0, 32'hFEED_0001, 16'd0);

    // Random transactions against the transaction-level model.
    do_reset();
    m_last = NH - 1;
    m_cnt  = '0;
    for (int n = 0; n < 60; n++) begin
      hreq = 3'($urandom_range(1, 7));
      for (int h = 0; h < NH; h++) begin
        case ($urandom_range(0, 4))
          0:       haddr[h] = 32'h0010_0000 | 32'($urandom_range(0, 32'hF_FFFF));
          1:       haddr[h] = 32'h0002_0000 | 32'($urandom_range(0, 32'hFFFF));
          2:       haddr[h] = 32'h0003_0000 | 32'($urandom_range(0, 32'hFFFF));
          3:       haddr[h] = 32'h0005_0000;
          default: haddr[h] = $urandom;
        endcase
      end
      lat   = $urandom_range(1, T + 2);
      derr  = 1'($urandom_range(0, 1));
      ddata = $urandom;

      w = -1;
      for (int i = 1; i <= NH; i++)
        if (w < 0 && hreq[(m_last + i) % NH]) w = (m_last + i) % NH;
      dv = model_decode(haddr[w]);
      if (dv < 0) begin
        cyc = 1; eerr = 1'b1; erd = 32'h0;
      end else if (lat <= T) begin
        cyc = lat; eerr = derr; erd = ddata;
      end else begin
        cyc = T; eerr = 1'b1; erd = 32'h0;
      end

      run_txn(w, dv, lat, derr, ddata, cyc, eerr, erd, m_cnt);

      m_last = w;
      if ((dv < 0 || lat > T) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end

    hreq = '0; apply_hosts(); clear_dev();
    @(negedge clk);
    check_outs(200, 3'b0, 3'b0, 3'b0, 3'b0, 32'h0, m_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_host_bus.md
# multi_host_bus

Parametrised successor to the single-host simple-system bus: connects `NrHosts` requesters to `NrDevices` memory-mapped devices over one shared channel. Adds fair round-robin arbitration, variable device response latency, an unmapped-address error response and a response timeout. It sits in the system top between the core data ports, plus any future DMA or debug hosts, and the RAM, simulator control and timer devices.

## Interface
- `NrHosts`, 2: number of hosts (1..16).
- `NrDevices`, 3: number of devices (1..16).
- `DataWidth`, 32: data bus width; byte enables are `DataWidth/8` bits.
- `AddressWidth`, 32: address width.
- `TimeoutCycles`, 64: cycles to wait for `device_rvalid_i` before returning an error (≥2).
- `clk_i  in  1  system clock`
- `rst_i  in  1  synchronous, active-high reset`
- `host_req_i / host_addr_i / host_we_i / host_be_i / host_wdata_i  in  [NrHosts] x (1/AW/1/DW/8/DW)  host request`
- `host_gnt_o  out  [NrHosts] x 1  request accepted this cycle`
- `host_rvalid_o / host_rdata_o / host_err_o  out  [NrHosts] x (1/DW/1)  host response`
- `device_req_o / device_addr_o / device_we_o / device_be_o / device_wdata_o  out  [NrDevices] x (1/AW/1/DW/8/DW)  device request`
- `device_rvalid_i / device_rdata_i / device_err_i  in  [NrDevices] x (1/DW/1)  device response`
- `cfg_device_addr_base / cfg_device_addr_mask  in  [NrDevices] x AW  address map`
- `err_count_o  out  16  saturating count of decode and timeout errors`

## Operation
- FSM states: IDLE, WAIT_RESP, ERR_RESP.
- IDLE:
  - Arbitrate among hosts with `host_req_i` high, round-robin, starting search at `last_host+1` (mod NrHosts).
  - Winner gets `host_gnt_o` high combinationally in the same cycle.
  - `last_host` is updated to the winner, and the winner's index and the decoded device are registered.
- Decode: device d hits when `(addr & mask[d]) == base[d]`. On overlapping hits the lowest index wins.
- Hit:
  - `device_req_o[d]` is high for exactly that cycle, with addr/we/be/wdata forwarded unchanged.
  - Next state WAIT_RESP; timeout counter cleared.
- No hit:
  - No device request is issued; next state ERR_RESP.
  - ERR_RESP drives `host_rvalid_o=1`, `host_err_o=1`, `rdata=0` to the owner for one cycle, then returns to IDLE.
- WAIT_RESP:
  - When `device_rvalid_i` of the selected device is high, pass rvalid/rdata/err combinationally to the owning host and go to IDLE.
  - Otherwise increment the counter. When the counter reaches `TimeoutCycles-1` without rvalid, respond as in ERR_RESP on that cycle and go to IDLE.
- rvalid from non-selected devices, or any device rvalid while in IDLE, is dropped.
- `err_count_o` increments on each decode or timeout error response, saturating at 0xFFFF. Device-signalled errors are not counted.
- Only the owning host ever sees `host_rvalid_o`; all other hosts' rvalid/err stay 0 and their rdata stays 0.

## Timing
- Reset values:
  - All `host_gnt_o`, `host_rvalid_o`, `host_err_o` and `device_req_o` = 0; `host_rdata_o` = 0.
  - `err_count_o` = 0; state IDLE.
  - `last_host = NrHosts-1`, so host 0 wins the first arbitration.
- Latency:
  - Grant in cycle 0 (same cycle as request).
  - Earliest response in cycle 1, for a device replying one cycle after req.
  - Decode error response in cycle 1.
  - Timeout response in cycle `TimeoutCycles`.
- Throughput: no grant is issued outside IDLE. With 1-cycle devices, one transaction completes every 2 cycles.
- A host holds its request until granted. A request deasserted before grant is simply not serviced.
- Reset asserted mid-transaction: return to IDLE next edge. No response is issued for the pending transaction. A late device rvalid after reset is dropped.
- Device-side outputs other than `device_req_o` are don't-care when req is low (they are driven with the current host's fields).

## Test plan
- Single host read from RAM (base 0x100000) with 1-cycle device: grant cycle 0, `host_rvalid_o[0]=1` with device data in cycle 1, `err=0`.
- All hosts (NrHosts=3) requesting continuously: grants go 0,1,2,0,1,2 on every second cycle. No host is granted twice before the others.
- Access to 0x50000 (unmapped): no `device_req_o` asserted; cycle 1 gives `rvalid=1`, `err=1`, `rdata=0`; `err_count_o` goes 0→1.
- Device never responds, TimeoutCycles=8: error response in cycle 8, then IDLE. A device rvalid injected in cycle 10 is not forwarded to any host.
- Device response with `device_err_i=1` at latency 3: the host sees `rvalid=1`, `err=1` in cycle 3 and `err_count_o` is unchanged.
- Reset pulsed in WAIT_RESP: no host rvalid afterwards, and the next grant goes to host 0.
